// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble
// insertion and a saturating bubble counter.
//
// Edge priority: flush > stall > load-use bubble > normal capture.
// Operands alu_a / alu_b / ex_store_data are resolved combinationally
// from the registered EX slot and the EX/MEM and MEM/WB write-back buses.
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  input  logic [31:0]      imm,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  input  logic [4:0]       rd_addr,
  input  logic [2:0]       alu_op_in,
  input  logic             alu_src,
  input  logic             reg_write_in,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic             exmem_reg_write,
  input  logic             memwb_reg_write,
  input  logic [4:0]       exmem_rd,
  input  logic [4:0]       memwb_rd,
  input  logic [31:0]      exmem_result,
  input  logic [31:0]      memwb_result,
  output logic             ex_valid,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       ex_alu_op,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic [31:0]      ex_pc,
  output logic [31:0]      ex_store_data,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Registered data fields of the EX slot that feed the operand muxes.
  logic [31:0] rs1_data_q;
  logic [31:0] rs2_data_q;
  logic [31:0] imm_q;
  logic [4:0]  rs1_addr_q;
  logic [4:0]  rs2_addr_q;
  logic        alu_src_q;

  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;

  // Load-use detection: the load in EX produces its data too late for the
  // instruction in decode, so decode must be held for one cycle.
  assign hazard_stall = in_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                        ((ex_rd == rs1_addr) | (ex_rd == rs2_addr));

  // EX slot register: flush, hold, bubble or capture, in that priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_alu_op    <= 3'b000;
      ex_rd        <= 5'd0;
      ex_pc        <= 32'd0;
      rs1_data_q   <= 32'd0;
      rs2_data_q   <= 32'd0;
      imm_q        <= 32'd0;
      rs1_addr_q   <= 5'd0;
      rs2_addr_q   <= 5'd0;
      alu_src_q    <= 1'b0;
      bubble_count <= '0;
    end else if (flush) begin
      // Squash only; data fields are left as they were since nothing reads
      // them while ex_valid is low. Flushes are not counted as bubbles.
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (stall) begin
      // Downstream hold: every register keeps its value.
    end else if (hazard_stall) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      if (bubble_count != CNT_MAX) begin
        bubble_count <= bubble_count + CNT_ONE;
      end
    end else if (in_valid) begin
      ex_valid     <= 1'b1;
      ex_reg_write <= reg_write_in;
      ex_mem_read  <= mem_read_in;
      ex_mem_write <= mem_write_in;
      ex_alu_op    <= alu_op_in;
      ex_rd        <= rd_addr;
      ex_pc        <= pc_in;
      rs1_data_q   <= rs1_data;
      rs2_data_q   <= rs2_data;
      imm_q        <= imm;
      rs1_addr_q   <= rs1_addr;
      rs2_addr_q   <= rs2_addr;
      alu_src_q    <= alu_src;
    end else begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end
  end

  // Forwarding: the younger EX/MEM result wins over MEM/WB; x0 never forwards.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    fwd_rs2 = rs2_data_q;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs1_addr_q)) begin
      fwd_rs1 = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs1_addr_q)) begin
      fwd_rs1 = memwb_result;
    end
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs2_addr_q)) begin
      fwd_rs2 = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs2_addr_q)) begin
      fwd_rs2 = memwb_result;
    end
  end

  assign alu_a         = fwd_rs1;
  assign alu_b         = alu_src_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: CNT_W, 16, bubble counter width.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 in_valid  in  1  decode stage presents a valid instruction.
REQ-006 stall  in  1  downstream hold request.
REQ-007 flush  in  1  branch/jump squash of the EX slot.
REQ-008 pc_in, rs1_data, rs2_data, imm  in  32 each  decoded PC, register-file reads and sign-extended immediate.
REQ-009 rs1_addr, rs2_addr, rd_addr  in  5 each  source and destination register indices.
REQ-010 alu_op_in  in  3  ALU encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SLT.
REQ-011 alu_src, reg_write_in, mem_read_in, mem_write_in  in  1 each  operand-B select (1 = imm) and control bits.
REQ-012 exmem_reg_write, memwb_reg_write  in  1 each; exmem_rd, memwb_rd  in  5 each; exmem_result, memwb_result  in  32 each  forwarding sources.
REQ-013 ex_valid  out  1  EX slot holds a real instruction.
REQ-014 alu_a, alu_b  out  32 each  forwarded ALU operands.
REQ-015 ex_alu_op  out  3; ex_rd  out  5; ex_reg_write, ex_mem_read, ex_mem_write  out  1 each; ex_pc, ex_store_data  out  32 each.
REQ-016 hazard_stall  out  1  load-use hold request to fetch/decode.
REQ-017 bubble_count  out  CNT_W  saturating count of inserted bubbles.

Function
REQ-018 Per edge, priority is: flush > stall > load-use > normal capture.
REQ-019 Normal capture: when in_valid=1 and no higher-priority event, all inputs are registered; ex_valid<=1; one-cycle latency.
REQ-020 in_valid=0 with no higher-priority event: ex_valid<=0; ex_reg_write, ex_mem_read, ex_mem_write<=0.
REQ-021 flush=1: ex_valid and all control bits <=0 regardless of stall or hazard; data fields don't-care.
REQ-022 stall=1 (no flush): every register holds its value; bubble_count unchanged.
REQ-023 hazard_stall is combinational = in_valid & ex_valid & ex_mem_read & (ex_rd!=0) & (ex_rd==rs1_addr | ex_rd==rs2_addr).
REQ-024 When hazard_stall=1 and no flush/stall: a bubble is inserted (ex_valid and control bits <=0); the decoded instruction is not captured and upstream must re-present it next cycle.
REQ-025 bubble_count increments by 1 per inserted load-use bubble and saturates at 2^CNT_W-1; flushes do not count.
REQ-026 Forwarding for each registered source (rs1, rs2): if exmem_reg_write & exmem_rd!=0 & exmem_rd==src use exmem_result; else if memwb_reg_write & memwb_rd!=0 & memwb_rd==src use memwb_result; else registered register-file data.
REQ-027 Register index 0 is never forwarded; its operand is the registered data unchanged.
REQ-028 alu_a = forwarded rs1; alu_b = registered imm when alu_src=1, else forwarded rs2; ex_store_data = forwarded rs2 always.
REQ-029 alu_a, alu_b, ex_store_data are combinational from registered state and forwarding inputs (zero added latency).
REQ-030 All other outputs come directly from registers.

Reset
REQ-031 rst_n=0 asynchronously forces all registers to 0: ex_valid=0, control bits=0, ex_alu_op=000, ex_rd=0, ex_pc=0, bubble_count=0.
REQ-032 Reset asserted mid-operation discards the EX instruction; first capture after release follows REQ-019.
REQ-033 hazard_stall=0 whenever ex_valid=0, including during reset.

Verification
REQ-034 Capture: in_valid=1, rs1_data=5, imm=7, alu_src=1, alu_op_in=000 -> next cycle ex_valid=1, alu_a=5, alu_b=7, ex_alu_op=000.
REQ-035 Forward priority: registered rs1_addr=3, exmem_rd=3 result 0xAA, memwb_rd=3 result 0xBB, both writes=1 -> alu_a=0xAA; clear exmem_reg_write -> alu_a=0xBB.
REQ-036 x0: rs2_addr=0, exmem_rd=0, exmem_reg_write=1, exmem_result=0xFF, rs2_data=0 -> alu_b=0, ex_store_data=0.
REQ-037 Load-use: EX holds lw to x5, decode presents add with rs1=x5 -> hazard_stall=1, next cycle ex_valid=0, bubble_count=1; re-presented add captured the following cycle.
REQ-038 Flush+stall same edge with ex_valid=1 -> ex_valid=0, ex_reg_write=0; stall alone -> all outputs held for 3 cycles.
REQ-039 Assert rst_n=0 between clock edges with ex_valid=1, bubble_count=4 -> ex_valid=0 and bubble_count=0 immediately, before the next edge.
